// File: rtl/mem_arbiter_seq.sv
// mem_arbiter_seq: fixed-priority arbiter running 1-4 byte transfers onto a byte-wide RAM port
module mem_arbiter_seq #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*2-1:0]          len_i,
  input  logic [NUM_PORTS*32-1:0]         wdata_i,
  output logic [NUM_PORTS-1:0]            done_o,
  output logic [NUM_PORTS-1:0]            busy_o,
  output logic [31:0]                     rdata_o,
  output logic [ADDR_WIDTH-1:0]           mem_a_o,
  output logic                            mem_wr_o,
  output logic [7:0]                      mem_dout_o,
  input  logic [7:0]                      mem_din_i
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] port_q, port_d, sel;
  logic any;
  logic we_q, we_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, a_q, a_d;
  logic [1:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] dout_q, dout_d;
  logic [NUM_PORTS-1:0] done_q, done_d, busy_q, busy_d;
  logic p0_v_q, p0_v_d, p1_v_q, p1_v_d;
  logic [1:0] p0_i_q, p0_i_d, p1_i_q, p1_i_d;
  logic last_cap;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign rdata_o = rdata_q;
  assign mem_a_o = a_q;
  assign mem_wr_o = wr_q & rdy;
  assign mem_dout_o = dout_q;
  // highest-index requester wins
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (req_i[k]) begin
        sel = PW'(k);
        any = 1'b1;
      end
    end
  end
  // next state; the capture tag follows the address every edge so a held address is re-captured into the right byte
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    we_d = we_q;
    base_d = base_q;
    len_d = len_q;
    wdata_d = wdata_q;
    idx_d = idx_q;
    a_d = a_q;
    wr_d = wr_q;
    dout_d = dout_q;
    done_d = done_q;
    busy_d = busy_q;
    p0_v_d = p0_v_q;
    p0_i_d = p0_i_q;
    p1_v_d = p0_v_q;
    p1_i_d = p0_i_q;
    rdata_d = rdata_q;
    if (p1_v_q) rdata_d[{p1_i_q, 3'b000} +: 8] = mem_din_i;
    last_cap = p1_v_q && (p1_i_q == len_q);
    if (rdy) begin
      case (state_q)
        IDLE: begin
          wr_d = 1'b0;
          if (any) begin
            port_d = sel;
            we_d = we_i[sel];
            base_d = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            len_d = len_i[int'(sel)*2 +: 2];
            wdata_d = wdata_i[int'(sel)*32 +: 32];
            a_d = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            wr_d = we_i[sel];
            dout_d = wdata_i[int'(sel)*32 +: 8];
            idx_d = 3'd1;
            busy_d = '0;
            busy_d[sel] = 1'b1;
            rdata_d = '0;
            p0_v_d = !we_i[sel];
            p0_i_d = 2'd0;
            state_d = XFER;
          end
        end
        XFER: begin
          if (idx_q <= {1'b0, len_q}) begin
            a_d = base_q + ADDR_WIDTH'(idx_q);
            wr_d = we_q;
            dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
            idx_d = idx_q + 3'd1;
            p0_v_d = !we_q;
            p0_i_d = idx_q[1:0];
          end else if (we_q || last_cap) begin
            wr_d = 1'b0;
            done_d[port_q] = 1'b1;
            p0_v_d = 1'b0;
            state_d = DONE;
          end
        end
        default: begin
          done_d = '0;
          busy_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q <= '0;
      we_q <= 1'b0;
      base_q <= '0;
      len_q <= '0;
      wdata_q <= '0;
      idx_q <= '0;
      a_q <= '0;
      wr_q <= 1'b0;
      dout_q <= '0;
      done_q <= '0;
      busy_q <= '0;
      rdata_q <= '0;
      p0_v_q <= 1'b0;
      p0_i_q <= '0;
      p1_v_q <= 1'b0;
      p1_i_q <= '0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      we_q <= we_d;
      base_q <= base_d;
      len_q <= len_d;
      wdata_q <= wdata_d;
      idx_q <= idx_d;
      a_q <= a_d;
      wr_q <= wr_d;
      dout_q <= dout_d;
      done_q <= done_d;
      busy_q <= busy_d;
      rdata_q <= rdata_d;
      p0_v_q <= p0_v_d;
      p0_i_q <= p0_i_d;
      p1_v_q <= p1_v_d;
      p1_i_q <= p1_i_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_seq.sv
// tb_mem_arbiter_seq: directed tests of the transfer arbiter against a byte RAM model
module tb_mem_arbiter_seq;
  localparam int NP = 2;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic [NP-1:0] req_i = '0;
  logic [NP-1:0] we_i = '0;
  logic [NP*AW-1:0] addr_i = '0;
  logic [NP*2-1:0] len_i = '0;
  logic [NP*32-1:0] wdata_i = '0;
  logic [NP-1:0] done_o, busy_o;
  logic [31:0] rdata_o;
  logic [AW-1:0] mem_a_o;
  logic mem_wr_o;
  logic [7:0] mem_dout_o;
  logic [7:0] mem_din_i;
  logic [7:0] ram [0:1023];
  logic ld = 1'b0;
  logic [9:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  logic [31:0] wl_a [0:63];
  logic [7:0] wl_d [0:63];
  int wn = 0;
  logic both_seen = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] aseq [0:15];
  logic [NP-1:0] bseq [0:15];

  always #5 clk = ~clk;

  mem_arbiter_seq #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .len_i(len_i), .wdata_i(wdata_i), .done_o(done_o), .busy_o(busy_o), .rdata_o(rdata_o),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i)
  );

  // synchronous RAM with a write log
  always @(posedge clk) begin
    if (ld) ram[ld_a] <= ld_d;
    else if (mem_wr_o) begin
      ram[mem_a_o[9:0]] <= mem_dout_o;
      wl_a[wn[5:0]] <= mem_a_o;
      wl_d[wn[5:0]] <= mem_dout_o;
      wn <= wn + 1;
    end
    mem_din_i <= ram[mem_a_o[9:0]];
  end

  always @(negedge clk) if (done_o == 2'b11) both_seen <= 1'b1;

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic start(input int p, input logic w, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    req_i[p] = 1'b1;
    we_i[p] = w;
    addr_i[p*AW +: AW] = a;
    len_i[p*2 +: 2] = l;
    wdata_i[p*32 +: 32] = d;
  endtask

  task automatic wait_done(input int p, output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 16) begin
        aseq[c] = mem_a_o;
        bseq[c] = busy_o;
      end
      if (done_o[p]) begin
        lat = c;
        break;
      end
    end
    req_i[p] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (done_o !== 2'b00) begin errors++; $display("FAIL reset_done got %h want 0", done_o); end
    if (busy_o !== 2'b00) begin errors++; $display("FAIL reset_busy got %h want 0", busy_o); end
    if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    if (mem_a_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_a_o); end
    if (mem_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", mem_wr_o); end
    if (mem_dout_o !== 8'h0) begin errors++; $display("FAIL reset_dout got %h want 0", mem_dout_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int lat;
    load(10'h100, 8'h11);
    load(10'h101, 8'h22);
    load(10'h102, 8'h33);
    load(10'h103, 8'h44);
    start(0, 1'b0, 32'h100, 2'd3, 32'h0);
    wait_done(0, lat);
    checks += 3;
    if (lat !== 5) begin errors++; $display("FAIL read_latency got %0d want 5", lat); end
    if (rdata_o !== 32'h44332211) begin errors++; $display("FAIL read_data got %h want 44332211", rdata_o); end
    if (bseq[0] !== 2'b01) begin errors++; $display("FAIL read_busy got %b want 01", bseq[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aseq[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL read_addr%0d got %h want %h", i, aseq[i], 32'h100 + 32'(i)); end
    end
    @(negedge clk);
    checks += 2;
    if (done_o !== 2'b00) begin errors++; $display("FAIL read_done_pulse got %b want 00", done_o); end
    if (busy_o !== 2'b00) begin errors++; $display("FAIL read_busy_clear got %b want 00", busy_o); end
  endtask

  task automatic test_write;
    int lat, n0;
    n0 = wn;
    start(1, 1'b1, 32'h200, 2'd1, 32'h0000BEEF);
    wait_done(1, lat);
    @(negedge clk);
    checks += 5;
    if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
    if (bseq[0] !== 2'b10) begin errors++; $display("FAIL write_busy got %b want 10", bseq[0]); end
    if (wn - n0 !== 2) begin errors++; $display("FAIL write_count got %0d want 2", wn - n0); end
    if ({wl_a[n0], wl_d[n0]} !== {32'h200, 8'hEF}) begin errors++; $display("FAIL write_byte0 got %h/%h want 200/EF", wl_a[n0], wl_d[n0]); end
    if ({wl_a[n0+1], wl_d[n0+1]} !== {32'h201, 8'hBE}) begin errors++; $display("FAIL write_byte1 got %h/%h want 201/BE", wl_a[n0+1], wl_d[n0+1]); end
  endtask

  task automatic test_simultaneous;
    int l0, l1;
    start(0, 1'b0, 32'h100, 2'd0, 32'h0);
    start(1, 1'b1, 32'h300, 2'd0, 32'h000000A5);
    wait_done(1, l1);
    wait_done(0, l0);
    checks += 6;
    if (l1 !== 1) begin errors++; $display("FAIL sim_p1_latency got %0d want 1", l1); end
    if (l0 !== 3) begin errors++; $display("FAIL sim_p0_latency got %0d want 3", l0); end
    if (bseq[1] !== 2'b01) begin errors++; $display("FAIL sim_p0_grant got %b want 01", bseq[1]); end
    if (rdata_o !== 32'h00000011) begin errors++; $display("FAIL sim_rdata got %h want 00000011", rdata_o); end
    if (ram[10'h300] !== 8'hA5) begin errors++; $display("FAIL sim_wbyte got %h want A5", ram[10'h300]); end
    if (both_seen !== 1'b0) begin errors++; $display("FAIL sim_both_done got %b want 0", both_seen); end
    @(negedge clk);
  endtask

  task automatic test_pause_read;
    int lat;
    start(0, 1'b0, 32'h100, 2'd3, 32'h0);
    fork
      wait_done(0, lat);
      begin
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
      end
    join
    checks += 4;
    if (lat !== 8) begin errors++; $display("FAIL pread_latency got %0d want 8", lat); end
    if (rdata_o !== 32'h44332211) begin errors++; $display("FAIL pread_data got %h want 44332211", rdata_o); end
    if (aseq[4] !== 32'h101) begin errors++; $display("FAIL pread_hold_addr got %h want 101", aseq[4]); end
    if (aseq[5] !== 32'h102) begin errors++; $display("FAIL pread_resume_addr got %h want 102", aseq[5]); end
    @(negedge clk);
  endtask

  task automatic test_pause_write;
    int lat, n0;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
    n0 = wn;
    start(1, 1'b1, 32'h240, 2'd3, 32'h12345678);
    fork
      wait_done(1, lat);
      begin
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        #1;
        checks++;
        if (mem_wr_o !== 1'b0) begin errors++; $display("FAIL pwrite_strobe got %b want 0", mem_wr_o); end
        repeat (2) @(negedge clk);
        rdy = 1'b1;
      end
    join
    @(negedge clk);
    checks += 2;
    if (lat !== 6) begin errors++; $display("FAIL pwrite_latency got %0d want 6", lat); end
    if (wn - n0 !== 4) begin errors++; $display("FAIL pwrite_count got %0d want 4", wn - n0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wl_a[n0+i], wl_d[n0+i]} !== {32'h240 + 32'(i), exp_b[i]})
        begin errors++; $display("FAIL pwrite_byte%0d got %h/%h want %h/%h", i, wl_a[n0+i], wl_d[n0+i], 32'h240 + 32'(i), exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic seen;
    start(0, 1'b0, 32'h100, 2'd3, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_i[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, rdata_o, mem_a_o, mem_wr_o, mem_dout_o} !== '0)
      begin errors++; $display("FAIL rmid_outputs got %h/%h/%h/%h/%b/%h want all 0", done_o, busy_o, rdata_o, mem_a_o, mem_wr_o, mem_dout_o); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_o !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_done got %b want 0", seen); end
    start(0, 1'b0, 32'h102, 2'd1, 32'h0);
    wait_done(0, lat);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", lat); end
    if (rdata_o !== 32'h00004433) begin errors++; $display("FAIL rmid_data got %h want 00004433", rdata_o); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write;
    test_simultaneous;
    test_pause_read;
    test_pause_write;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
